// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift a byte with odd parity, sample the device ack.
// Optional response watchdog is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int CLK_INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES     = 375000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       ack_err,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam int                 INH_W    = $clog2(CLK_INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0]   INH_LAST = INH_W'(CLK_INHIBIT_CYCLES - 1);

    if (CLK_INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("ps2_host_tx: cycle-count parameters must be at least 1");
    end

    state_t           state;
    state_t           next_state;
    logic             clk_meta, clk_sync, clk_prev;
    logic             dat_meta, dat_sync;
    logic             fall;
    logic [INH_W-1:0] inh_cnt;
    logic [3:0]       edge_cnt;
    logic [8:0]       frame;
    logic             ack_q;
    logic             accept;
    logic             timeout;
    logic             clk_oe_d;
    logic             dat_oe_d;

    assign fall   = clk_prev & ~clk_sync;
    assign accept = tx_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them see the pre-edge values, whatever the statement order.
        if (rst) begin
            clk_meta   <= 1'b1;
            clk_sync   <= 1'b1;
            clk_prev   <= 1'b1;
            dat_meta   <= 1'b1;
            dat_sync   <= 1'b1;
            state      <= IDLE;
            inh_cnt    <= '0;
            edge_cnt   <= '0;
            frame      <= '0;
            ack_q      <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            clk_meta   <= ps2_clk_in;
            clk_sync   <= clk_meta;
            clk_prev   <= clk_sync;
            dat_meta   <= ps2_dat_in;
            dat_sync   <= dat_meta;
            state      <= next_state;
            ps2_clk_oe <= clk_oe_d;
            ps2_dat_oe <= dat_oe_d;
            inh_cnt    <= (state == INHIBIT) ? inh_cnt + 1'b1 : '0;

            // Frame bit 8 is odd parity; edge counter saturates at the ack edge.
            if (accept) begin
                frame    <= {~^tx_data, tx_data};
                edge_cnt <= '0;
                ack_q    <= 1'b0;
            end else if (fall && edge_cnt != 4'd11 &&
                         (state == REQ || state == SHIFT || state == ACK)) begin
                edge_cnt <= edge_cnt + 4'd1;
            end

            if (state == ACK && fall)
                ack_q <= dat_sync;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_active;

    assign wd_active = (state == REQ) || (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
    assign timeout   = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !wd_active || fall)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: default assignment first so no path through this block can infer a latch.
        next_state = state;
        case (state)
            IDLE:      if (tx_valid) next_state = INHIBIT;
            INHIBIT:   if (inh_cnt == INH_LAST) next_state = REQ;
            REQ:       if (fall) next_state = SHIFT;
            SHIFT:     if (fall && edge_cnt == 4'd9) next_state = ACK;
            ACK:       if (fall) next_state = WAIT_IDLE;
            WAIT_IDLE: if (clk_sync && dat_sync) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (timeout)
            next_state = IDLE;
    end

    // Line enables are computed one cycle ahead and registered so the pads never glitch.
    always_comb begin
        tx_ready = (state == IDLE);
        busy     = (state != IDLE);
        done     = !rst && ((state == WAIT_IDLE && clk_sync && dat_sync) || timeout);
        ack_err  = ack_q || timeout;
        clk_oe_d = (next_state == INHIBIT);
        dat_oe_d = ps2_dat_oe;
        case (state)
            INHIBIT:    dat_oe_d = (next_state == REQ);
            REQ, SHIFT: if (fall) dat_oe_d = (edge_cnt <= 4'd8) ? ~frame[edge_cnt] : 1'b0;
            default:    dat_oe_d = 1'b0;
        endcase
        if (timeout)
            dat_oe_d = 1'b0;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a behavioural keyboard that clocks, captures and acks each frame.
// Build with PS2_TX_TIMEOUT_EN defined to exercise the watchdog path instead of the wait-forever path.
module tb_ps2_host_tx;

    localparam int CLK_INH    = 2500;
    localparam int TB_TIMEOUT = 3000;
    localparam int HALF       = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, done, ack_err, busy;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk, dev_dat;
    logic       ps2_clk_in, ps2_dat_in;

    int         checks   = 0;
    int         failures = 0;
    int         done_count = 0;
    logic       last_ack_err = 1'b0;
    logic       expect_done  = 1'b0;
    logic       prev_done    = 1'b0;
    logic       mon_en       = 1'b0;

    // Wired-AND bus: either side can pull a line low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_INHIBIT_CYCLES(CLK_INH),
        .TIMEOUT_CYCLES    (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (done),
        .ack_err   (ack_err),
        .busy      (busy),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected frame as the device sees it: {stop, odd parity, data}, bit 0 sent first.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0), b};
    endfunction

    // Per-cycle compare against the protocol rules, plus done bookkeeping.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                check("done_expected", expect_done, 1'b1);
                expect_done  = 1'b0;
                done_count++;
                last_ack_err = ack_err;
            end
            if (prev_done && !rst) begin
                check("ready_after_done", tx_ready, 1'b1);
                check("lines_after_done", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
            end
            check("busy_vs_ready", busy, !tx_ready);
            check("oe_exclusive", ps2_clk_oe & ps2_dat_oe, 1'b0);
            prev_done = done;
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("ready_drop", tx_ready, 1'b0);
        check("busy_rise", busy, 1'b1);
    endtask

    // Keyboard model: measures the inhibit, then gives n_edges clock pulses, sampling data on rising edges.
    task automatic device_run(input logic ack_val, input int n_edges,
                              output logic [9:0] bits, output int inh_len);
        int guard;
        bits    = '0;
        inh_len = 0;
        guard   = 0;
        while (!ps2_clk_oe && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("inhibit_start", ps2_clk_oe, 1'b1);
        while (ps2_clk_oe && inh_len < 10000) begin
            @(negedge clk);
            inh_len++;
        end
        check("start_bit", ps2_dat_oe, 1'b1);
        for (int k = 1; k <= n_edges; k++) begin
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            if (k == n_edges && n_edges < 11) return;
            repeat (HALF) @(negedge clk);
            if (k <= 10) bits[k-1] = ps2_dat_in;
            dev_clk = 1'b1;
            if (k == 10) dev_dat = ack_val;
            if (k == 11) expect_done = 1'b1;
        end
        if (n_edges == 11) begin
            repeat (HALF) @(negedge clk);
            dev_dat = 1'b1;
        end
    endtask

    task automatic transfer(input logic [7:0] b, input logic ack_val,
                            input logic [9:0] lit, input logic exp_err);
        logic [9:0] bits;
        int         inh;
        int         start;
        int         guard;
        send(b);
        start = done_count;
        device_run(ack_val, 11, bits, inh);
        check("inhibit_len", inh, CLK_INH);
        check("frame_model", bits, frame_of(b));
        check("frame_literal", bits, lit);
        guard = 0;
        while (done_count == start && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("done_count", done_count - start, 1);
        check("ack_err", last_ack_err, exp_err);
        repeat (3) @(negedge clk);
        check("lines_idle", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1);
    end

    initial begin
        logic [9:0] bits;
        int         inh;
        int         lat;
        int         start;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_dat_oe", ps2_dat_oe, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        transfer(8'hED, 1'b0, 10'h3ED, 1'b0);
        transfer(8'h01, 1'b0, 10'h201, 1'b0);
        transfer(8'hFF, 1'b0, 10'h3FF, 1'b0);
        transfer(8'h5A, 1'b1, 10'h35A, 1'b1);

        // A second request arriving mid-transfer must be dropped.
        send(8'hED);
        start = done_count;
        fork
            device_run(1'b0, 11, bits, inh);
            begin
                repeat (100) @(negedge clk);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        check("busy_ignore_frame", bits, 10'h3ED);
        repeat (50) @(negedge clk);
        check("busy_ignore_done", done_count - start, 1);
        check("busy_ignore_idle", busy, 1'b0);
        check("busy_ignore_no_inhibit", ps2_clk_oe, 1'b0);

        // Reset in the middle of the data bits.
        send(8'h3C);
        device_run(1'b0, 5, bits, inh);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        check("midrst_tx_ready", tx_ready, 1'b1);
        check("midrst_done", done, 1'b0);
        @(negedge clk);
        rst     = 1'b0;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (10) @(negedge clk);
        transfer(8'hF4, 1'b0, 10'h2F4, 1'b0);

        // Device never clocks after the request-to-send.
        send(8'hA5);
        start = done_count;
        device_run(1'b1, 0, bits, inh);
`ifdef PS2_TX_TIMEOUT_EN
        expect_done = 1'b1;
        lat = 1;
        while (!done && lat < TB_TIMEOUT + 100) begin
            @(negedge clk);
            lat++;
        end
        check("timeout_latency", lat, TB_TIMEOUT);
        check("timeout_done", done, 1'b1);
        check("timeout_ack_err", ack_err, 1'b1);
        @(negedge clk);
        check("timeout_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        check("timeout_ready", tx_ready, 1'b1);
`else
        lat = 0;
        repeat (5000) @(negedge clk);
        check("stall_busy", busy, 1'b1);
        check("stall_start_bit", ps2_dat_oe, 1'b1);
        check("stall_no_done", done_count - start, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("stall_rst_busy", busy, 1'b0);
        check("stall_rst_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
`endif
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_INHIBIT_CYCLES, default 2500, setting how long the host holds PS/2 clock low for a request-to-send (100 us at 25 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 375000, setting the watchdog limit for a device response (15 ms at 25 MHz).
REQ-003 SHALL have port clk, input, 1 bit: the single 25 MHz system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port tx_data, input, 8 bits: the command byte to send to the keyboard.
REQ-006 SHALL have port tx_valid, input, 1 bit: request to send tx_data.
REQ-007 SHALL have port tx_ready, output, 1 bit: the block is idle and will accept a byte.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when a transfer ends.
REQ-009 SHALL have port ack_err, output, 1 bit: valid while done=1; 1 means missing ack or timeout.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE; the keyboard receiver ignores the bus while busy=1.
REQ-011 SHALL have port ps2_clk_in, input, 1 bit: raw (asynchronous) PS/2 clock line level.
REQ-012 SHALL have port ps2_dat_in, input, 1 bit: raw (asynchronous) PS/2 data line level.
REQ-013 SHALL have port ps2_clk_oe, output, 1 bit: 1 pulls the PS/2 clock line low; 0 releases it (open-drain).
REQ-014 SHALL have port ps2_dat_oe, output, 1 bit: 1 pulls the PS/2 data line low; 0 releases it (open-drain).

Function
REQ-015 SHALL pass ps2_clk_in and ps2_dat_in through 2-FF synchronizers and detect the clock falling edge from the synchronized clock and its previous value.
REQ-016 SHALL accept a byte when tx_valid&&tx_ready, latching tx_data and odd parity (parity = ~^tx_data); tx_ready SHALL be 0 from the next cycle.
REQ-017 SHALL ignore tx_valid while busy; no queuing.
REQ-018 SHALL implement states IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-019 IDLE->INHIBIT on accept; INHIBIT drives clk_oe=1, dat_oe=0 for exactly CLK_INHIBIT_CYCLES cycles.
REQ-020 INHIBIT->REQ: dat_oe=1 (start bit), clk_oe=0 from the same cycle onward.
REQ-021 REQ->SHIFT on first falling edge; falling edges 1..8 SHALL set dat_oe=~bit[n-1] (LSB first), edge 9 dat_oe=~parity, edge 10 dat_oe=0 (stop), then ->ACK.
REQ-022 ACK: on the 11th falling edge sample synced data; 0=ack ok, 1=ack_err; ->WAIT_IDLE.
REQ-023 WAIT_IDLE: when synced clk and data are both 1, pulse done for one cycle with ack_err held, then ->IDLE with tx_ready=1 in the cycle after done.
REQ-024 The 4-bit edge counter SHALL be reset on accept and SHALL not wrap past 11.
REQ-025 ps2_clk_oe and ps2_dat_oe SHALL be registered outputs, glitch-free.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, clk_oe=0, dat_oe=0, tx_ready=1, busy=0, done=0, ack_err=0, counters=0, synchronizers=1.
REQ-027 rst mid-transfer SHALL release both lines in the cycle after rst is sampled and SHALL NOT pulse done.

Configuration
REQ-028 Macro PS2_TX_TIMEOUT_EN defined: a watchdog counter runs in REQ/SHIFT/ACK/WAIT_IDLE, restarts on each falling edge, and on reaching TIMEOUT_CYCLES releases both lines, pulses done with ack_err=1, and goes to IDLE.
REQ-029 Macro undefined: no watchdog; the block waits indefinitely for device clocks, and ack_err comes only from the ack sample.

Verification
REQ-030 Send 0xED, the device model clocks and acks: clk low for 2500 cycles, then bits 1,0,1,1,0,1,1,1 LSB first, parity=1, stop, done=1 with ack_err=0.
REQ-031 Send 0x01: parity bit=0; send 0xFF: parity=1; bus bits match at each device rising edge.
REQ-032 Device holds data high at the 11th edge: done=1, ack_err=1, lines released.
REQ-033 With PS2_TX_TIMEOUT_EN defined and no device clocks after REQ: done at 375000 cycles with ack_err=1; macro undefined: busy stays 1 and the bench releases with rst.
REQ-034 rst asserted at edge 5: next cycle oe=0/0, tx_ready=1, no done pulse; a fresh 0xF4 then completes normally.
REQ-035 tx_valid pulsed with 0x55 during a busy 0xED transfer: ignored; only 0xED appears on the bus.
